// File: rtl/second_counter.sv
`default_nettype none
// ============================================================================
// Module      : second_counter
// Description : Seconds stage of the clock datapath. Divides clk down to a
//               once-per-second tick, counts seconds 0..59, emits a one-cycle
//               ClkSecond pulse per tick and a one-cycle ClkMinute pulse on
//               the counted 59->0 wrap. In edit mode counting freezes and the
//               active-low KeyPlus/KeyMinus keys step the selected digit.
// Revision    : 1.0 - initial release
// ============================================================================
module second_counter #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       EditMode,
  input  logic [2:0] EditPos,
  input  logic [1:0] screen,
  input  logic       KeyPlus,
  input  logic       KeyMinus,
  output logic [5:0] seconds,
  output logic       ClkSecond,
  output logic       ClkMinute
);

  // Prescaler is at least one bit wide so TICK_DIV=1 still builds; with a
  // terminal count of 0 it then ticks on every edge.
  localparam int              C_PRESCALE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [C_PRESCALE_W-1:0] C_LAST  = C_PRESCALE_W'(TICK_DIV - 1);
  localparam logic [C_PRESCALE_W-1:0] C_ONE   = C_PRESCALE_W'(1);

  logic [C_PRESCALE_W-1:0] r_prescale;
  logic                    r_plus_q;
  logic                    r_minus_q;

  logic [5:0] w_ones;
  logic       w_plus_press;
  logic       w_minus_press;
  logic       w_edit_en;
  logic       w_step;
  logic [5:0] w_edit_val;

  // Key press detection and the digit-wise edited seconds value.
  always_comb begin
    w_ones        = seconds % 6'd10;
    w_plus_press  = r_plus_q  & ~KeyPlus;
    w_minus_press = r_minus_q & ~KeyMinus;
    w_edit_en     = EditMode & (screen == 2'd0) & (EditPos <= 3'd1);
    // Simultaneous presses cancel out; a lone press produces one step.
    w_step        = w_edit_en & (w_plus_press ^ w_minus_press);
    w_edit_val    = seconds;
    if (EditPos == 3'd0) begin
      // Ones digit wraps inside its own decade, no carry into tens.
      if (w_plus_press) begin
        w_edit_val = (w_ones == 6'd9) ? seconds - 6'd9 : seconds + 6'd1;
      end else begin
        w_edit_val = (w_ones == 6'd0) ? seconds + 6'd9 : seconds - 6'd1;
      end
    end else begin
      // Tens digit wraps 0..5, ones digit untouched.
      if (w_plus_press) begin
        w_edit_val = (seconds >= 6'd50) ? seconds - 6'd50 : seconds + 6'd10;
      end else begin
        w_edit_val = (seconds < 6'd10) ? seconds + 6'd50 : seconds - 6'd10;
      end
    end
  end

  // Prescaler, seconds count, registered tick pulses, key history and edits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prescale <= '0;
      r_plus_q   <= 1'b1;
      r_minus_q  <= 1'b1;
      seconds    <= 6'd0;
      ClkSecond  <= 1'b0;
      ClkMinute  <= 1'b0;
    end else begin
      r_plus_q  <= KeyPlus;
      r_minus_q <= KeyMinus;
      ClkSecond <= 1'b0;
      ClkMinute <= 1'b0;
      if (EditMode) begin
        // Holding the prescaler at zero makes the first tick after leaving
        // edit mode land exactly TICK_DIV edges later.
        r_prescale <= '0;
        if (w_step) begin
          seconds <= w_edit_val;
        end
      end else if (r_prescale == C_LAST) begin
        r_prescale <= '0;
        ClkSecond  <= 1'b1;
        ClkMinute  <= (seconds == 6'd59);
        seconds    <= (seconds == 6'd59) ? 6'd0 : seconds + 6'd1;
      end else begin
        r_prescale <= r_prescale + C_ONE;
      end
    end
  end

endmodule
`default_nettype wire
